inport_fifo: RTL and testbench

Buffered input port that sits directly upstream of the datapath's InPort bus source. An external device pushes 32-bit words through a valid/ready handshake into a small FIFO. The CPU consumes one word per `in` instruction: the head word is presented on `Inport_data_out` while the control step asserts `InPortout`, and the word is popped when that strobe ends. Status outputs expose occupancy and an optional sticky underflow flag.

---
 rtl/inport_fifo_if.sv | 46 ++++
 rtl/inport_fifo.sv | 152 +++++++++++++++
 tb/tb_inport_fifo.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/inport_fifo_if.sv
// Handshake bundle between the external device, the control unit and inport_fifo.
// Groups the device push channel, the InPort read strobe/bus word and the status flags.
// Device side: dev_data/dev_valid in, dev_ready out. CPU side: InPortout, clr_flags in.
// Status out: Inport_data_out, fifo_count, empty, underflow.
interface inport_fifo_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] dev_data;
    logic              dev_valid;
    logic              dev_ready;
    logic              InPortout;
    logic [DATA_W-1:0] Inport_data_out;
    logic [CW-1:0]     fifo_count;
    logic              empty;
    logic              clr_flags;
    logic              underflow;

    // Environment side: the device and the control unit drive the inputs.
    modport master (
        output dev_data,
        output dev_valid,
        input  dev_ready,
        output InPortout,
        input  Inport_data_out,
        input  fifo_count,
        input  empty,
        output clr_flags,
        input  underflow
    );

    // FIFO side.
    modport slave (
        input  dev_data,
        input  dev_valid,
        output dev_ready,
        input  InPortout,
        output Inport_data_out,
        output fifo_count,
        output empty,
        input  clr_flags,
        output underflow
    );
endinterface

// File: rtl/inport_fifo.sv
// Buffered input port: small FIFO between an external device and the InPort bus source.
// Latency: pushed word visible on Inport_data_out 1 cycle after the push edge; pop on strobe fall.
// Backpressure: dev_ready low while full; device holds dev_data until accepted.
//
// Ports:
//   clk               system clock, rising edge
//   clr               asynchronous active-high reset
//   bus (slave)       dev_data/dev_valid/dev_ready push channel,
//                     InPortout read strobe, Inport_data_out head word,
//                     fifo_count/empty occupancy, clr_flags/underflow sticky flag
// Optional feature: define INPORT_UNDERFLOW_EN to build the sticky underflow flag;
// without it underflow is tied low and clr_flags is ignored.
module inport_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic         clk,
    input  logic         clr,
    inport_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              strobe_q;
    logic              armed;
    logic [DATA_W-1:0] last_q;

    logic              is_empty;
    logic              ready;
    logic              push;
    logic              pop;
    logic              rise;
    logic              fall;

    // ------------------------------------------------------------------
    // Handshake and strobe edge detection
    // ------------------------------------------------------------------
    assign is_empty = (count == '0);
    // Ready is taken from the registered count only, so a pop on the same
    // edge never lets a push into a full FIFO.
    assign ready    = (count != FULL_CNT);
    assign push     = bus.dev_valid && ready;

    assign rise     = bus.InPortout && !strobe_q;
    assign fall     = !bus.InPortout && strobe_q;
    // The pop is deferred to the falling edge of the strobe so the head word
    // is held steady on the bus for however long the control step lasts.
    assign pop      = fall && armed;

    // ------------------------------------------------------------------
    // Storage: contents are not reset, occupancy is tracked by count.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.dev_data;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rd_ptr <= '0;
            last_q <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            // Keep the popped word so the bus still shows it once empty.
            last_q <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Strobe tracking. armed records whether the strobe found data at its
    // start; a strobe that began empty never pops, even if a word arrives
    // while it is still high. Clearing strobe_q on reset makes a strobe
    // that is still high after reset look like a fresh rise.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= bus.InPortout;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            armed <= 1'b0;
        end else if (rise) begin
            armed <= !is_empty;
        end else if (fall) begin
            armed <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Sticky underflow flag
    // ------------------------------------------------------------------
`ifdef INPORT_UNDERFLOW_EN
    logic underflow_q;

    // A new underflow takes priority over a clear on the same edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            underflow_q <= 1'b0;
        end else if (rise && is_empty) begin
            underflow_q <= 1'b1;
        end else if (bus.clr_flags) begin
            underflow_q <= 1'b0;
        end
    end

    assign bus.underflow = underflow_q;
`else
    logic unused_clr_flags;

    assign unused_clr_flags = bus.clr_flags;
    assign bus.underflow    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.dev_ready       = ready;
    assign bus.fifo_count      = count;
    assign bus.empty           = is_empty;
    assign bus.Inport_data_out = is_empty ? last_q : mem[rd_ptr];

endmodule

// File: tb/tb_inport_fifo.sv
module tb_inport_fifo;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
`ifdef INPORT_UNDERFLOW_EN
    localparam logic UF = 1'b1;
`else
    localparam logic UF = 1'b0;
`endif

    logic clk;
    logic clr;
    int   n_assert;
    int   n_fail;

    inport_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    inport_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag, input logic [31:0] dat,
                              input logic [31:0] cnt, input logic rdy);
        chk({tag, "_data"},  bus.Inport_data_out, dat);
        chk({tag, "_count"}, 32'(bus.fifo_count), cnt);
        chk({tag, "_empty"}, 32'(bus.empty), 32'(cnt == 0));
        chk({tag, "_ready"}, 32'(bus.dev_ready), 32'(rdy));
    endtask

    task automatic push(input logic [31:0] d);
        bus.dev_valid = 1'b1;
        bus.dev_data  = d;
        tick();
        bus.dev_valid = 1'b0;
    endtask

    // Strobe for len cycles expecting exp on the bus, then drop it.
    task automatic strobe(input string tag, input logic [31:0] exp, input int len,
                          input logic [31:0] cnt_after);
        bus.InPortout = 1'b1;
        for (int i = 0; i < len; i++) begin
            tick();
            chk({tag, "_during"}, bus.Inport_data_out, exp);
        end
        bus.InPortout = 1'b0;
        tick();
        chk({tag, "_cnt_after"}, 32'(bus.fifo_count), cnt_after);
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        clr           = 1'b1;
        bus.dev_data  = '0;
        bus.dev_valid = 1'b0;
        bus.InPortout = 1'b0;
        bus.clr_flags = 1'b0;

        // Reset values
        #12;
        chk_status("reset", 32'h0, 0, 1'b1);
        chk("reset_uf", 32'(bus.underflow), 32'h0);
        tick();
        clr = 1'b0;
        tick();

        // Single word, 2-cycle strobe, output falls back to last_q
        push(32'hFFFE93C5);
        chk_status("push1", 32'hFFFE93C5, 1, 1'b1);
        strobe("rd1", 32'hFFFE93C5, 2, 0);
        chk_status("rd1_empty", 32'hFFFE93C5, 0, 1'b1);

        // Fill to full, fifth word held by device
        push(32'd1);
        push(32'd2);
        push(32'd3);
        push(32'd4);
        chk_status("full", 32'd1, 4, 1'b0);
        bus.dev_valid = 1'b1;
        bus.dev_data  = 32'd5;
        tick();
        chk_status("full_hold", 32'd1, 4, 1'b0);
        bus.InPortout = 1'b1;
        tick();
        chk_status("full_strobe", 32'd1, 4, 1'b0);
        bus.InPortout = 1'b0;
        tick();
        // Pop at this edge; 5 rejected because ready was low before it.
        chk_status("full_pop", 32'd2, 3, 1'b1);
        tick();
        bus.dev_valid = 1'b0;
        chk_status("accept5", 32'd2, 4, 1'b0);
        strobe("rd2", 32'd2, 1, 3);
        strobe("rd3", 32'd3, 3, 2);
        strobe("rd4", 32'd4, 1, 1);
        strobe("rd5", 32'd5, 2, 0);
        chk_status("drained", 32'd5, 0, 1'b1);

        // Strobe while empty
        strobe("uf_strobe", 32'd5, 1, 0);
        chk("uf_set", 32'(bus.underflow), 32'(UF));
        chk_status("uf_state", 32'd5, 0, 1'b1);
        bus.clr_flags = 1'b1;
        tick();
        bus.clr_flags = 1'b0;
        chk("uf_cleared", 32'(bus.underflow), 32'h0);
        // Set wins over clear on the same edge
        bus.clr_flags = 1'b1;
        bus.InPortout = 1'b1;
        tick();
        bus.clr_flags = 1'b0;
        chk("uf_set_wins", 32'(bus.underflow), 32'(UF));
        bus.InPortout = 1'b0;
        tick();
        bus.clr_flags = 1'b1;
        tick();
        bus.clr_flags = 1'b0;
        chk("uf_cleared2", 32'(bus.underflow), 32'h0);

        // Push on the exact falling edge of a strobe, count 2
        push(32'd10);
        push(32'd11);
        bus.InPortout = 1'b1;
        tick();
        bus.InPortout = 1'b0;
        bus.dev_valid = 1'b1;
        bus.dev_data  = 32'd12;
        tick();
        bus.dev_valid = 1'b0;
        chk_status("fall_push", 32'd11, 2, 1'b1);
        strobe("rd11", 32'd11, 1, 1);
        strobe("rd12", 32'd12, 1, 0);

        // Strobe begins empty, word arrives mid-strobe
        bus.InPortout = 1'b1;
        tick();
        bus.dev_valid = 1'b1;
        bus.dev_data  = 32'hA5;
        tick();
        bus.dev_valid = 1'b0;
        chk_status("mid_push", 32'hA5, 1, 1'b1);
        bus.InPortout = 1'b0;
        tick();
        chk_status("mid_nopop", 32'hA5, 1, 1'b1);
        chk("mid_uf", 32'(bus.underflow), 32'(UF));
        strobe("rdA5", 32'hA5, 1, 0);

        // Reset in the middle of a strobe with 3 words stored
        push(32'd21);
        push(32'd22);
        push(32'd23);
        bus.InPortout = 1'b1;
        tick();
        #2;
        clr = 1'b1;
        #1;
        chk_status("clr_mid", 32'h0, 0, 1'b1);
        chk("clr_uf", 32'(bus.underflow), 32'h0);
        tick();
        clr = 1'b0;
        tick();
        bus.InPortout = 1'b0;
        tick();
        chk_status("post_clr", 32'h0, 0, 1'b1);
        push(32'd30);
        chk_status("post_clr_push", 32'd30, 1, 1'b1);
        strobe("rd30", 32'd30, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
